// File: rtl/interrupt_ctrl.sv
// Interrupt controller: IF/IE registers, edge capture with per-source ack, prioritised
// vector dispatch handshake. Optional macro INTC_DISPATCH_CANCEL_EN selects late (resolution-time) selection.
module interrupt_ctrl #(
  parameter int unsigned DISPATCH_DELAY = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  int_req,
  output logic [4:0]  int_ack,
  output logic        int_pending,
  input  logic        int_dispatch,
  output logic [7:0]  int_vector,
  output logic        int_vector_valid
);

  localparam int unsigned NSRC  = 5;
  localparam int unsigned CNT_W = 4;
  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state, w_state_next;
  logic [NSRC-1:0]    r_if;
  logic [7:0]         r_ie;
  logic [NSRC-1:0]    r_req_d;
  logic [NSRC-1:0]    r_ack;
  logic               r_disp_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [7:0]         r_vector;
  logic               r_valid;

  logic [NSRC-1:0]    w_edge, w_masked, w_sel, w_res_sel, w_clr;
  logic               w_rise, w_resolve, w_if_wr, w_ie_wr;
  logic [7:0]         w_vec;
  logic               w_unused_rd;

  assign w_unused_rd = rd;  // reads have no side effects

  assign w_edge   = int_req & ~r_req_d;
  assign w_rise   = int_dispatch & ~r_disp_d;
  assign w_masked = r_if & r_ie[NSRC-1:0];
  assign w_sel    = w_masked & (~w_masked + NSRC'(1));  // lowest set bit wins
  assign w_if_wr  = wr && (a == ADDR_IF);
  assign w_ie_wr  = wr && (a == ADDR_IE);

`ifdef INTC_DISPATCH_CANCEL_EN
  assign w_res_sel = w_sel;
`else
  logic [NSRC-1:0] r_snap;

  // Selection frozen on the dispatch rising cycle; IDLE path covers a one-cycle delay.
  assign w_res_sel = (r_state == S_IDLE) ? w_sel : r_snap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (r_state == S_IDLE && w_rise) begin
      r_snap <= w_sel;
    end
  end
`endif

  assign w_clr = w_resolve ? w_res_sel : '0;

  always_comb begin
    w_vec = 8'h00;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (w_res_sel[i]) w_vec = 8'h40 + 8'(i * 8);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_resolve    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          if (DISPATCH_DELAY <= 1) begin
            w_resolve    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_cnt_next   = CNT_W'(DISPATCH_DELAY - 1);
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!int_dispatch) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_cnt_next   = '0;
          w_resolve    = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!int_dispatch) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture beats both the CPU write and the dispatch clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if     <= '0;
      r_ie     <= '0;
      r_req_d  <= '0;
      r_ack    <= '0;
      r_disp_d <= 1'b0;
      r_vector <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_if     <= ((w_if_wr ? din[NSRC-1:0] : r_if) & ~w_clr) | w_edge;
      r_req_d  <= int_req;
      r_ack    <= w_edge;
      r_disp_d <= int_dispatch;
      r_valid  <= (r_state == S_HOLD) && int_dispatch;
      if (w_ie_wr)   r_ie     <= din;
      if (w_resolve) r_vector <= w_vec;
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (a == ADDR_IF)      dout = {3'b111, r_if};
    else if (a == ADDR_IE) dout = r_ie;
  end

  assign int_pending      = |w_masked;
  assign int_ack          = r_ack;
  assign int_vector       = r_vector;
  assign int_vector_valid = r_valid;

endmodule
